// File: rtl/sh_deserializer_pkg.sv
// Shared definitions for the sh_deserializer slice: FSM state encodings and
// the frame-length helper. SH_PARITY_EN adds one trailing even-parity bit per frame.
package sh_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] CLOSE = 2'd2;

  // Serial bits per frame: payload only, or payload plus parity.
  function automatic int frame_len(input int width);
`ifdef SH_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/sh_deserializer_if.sv
// Parallel-side bus of sh_deserializer: valid/ready word output plus the
// frame status pulses. The master is the deserializer and the slave is the consumer.
interface sh_deserializer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] word_o;
  logic             valid_o;
  logic             ready_i;
  logic             len_err_o;
  logic             ovf_o;
  logic             par_err_o;

  modport master (output word_o, valid_o, len_err_o, ovf_o, par_err_o, input ready_i);
  modport slave  (input word_o, valid_o, len_err_o, ovf_o, par_err_o, output ready_i);
endinterface

// File: rtl/sh_deserializer_out_buf.sv
// One-entry valid/ready holding register for completed frames.
// A load wins over a same-cycle transfer, so valid stays high in that cycle.
module sh_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic             full
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Hold the word until it is consumed; replace it only on a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= din;
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign dout  = r_data;
  assign full  = r_valid;

endmodule

// File: rtl/sh_deserializer.sv
// Serial-to-parallel frame capture behind the rfin/sh_en sync FSM.
// Optional feature macro: SH_PARITY_EN (trailing even-parity bit per frame).
//
// state | meaning
// IDLE  | waiting for active_i with sh_en_sync high
// SHIFT | sampling sdi one bit per clock while sh_en_sync is high
// CLOSE | one cycle: check length/parity, hand the word to the output buffer
module sh_deserializer
  import sh_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active_i,
  input  logic              sh_en_sync,
  input  logic              sdi,
  sh_deserializer_if.master bus
);

  localparam int               FRAME_LEN = frame_len(WIDTH);
  localparam logic [CNT_W-1:0] LEN_C     = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] SAT_C     = CNT_W'(FRAME_LEN + 1);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [FRAME_LEN-1:0] r_shreg;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_sh_en_prev;

  logic w_close, w_len_bad, w_par_bad, w_good, w_load, w_ovf, w_full;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; losing active_i outranks the sh_en falling edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (active_i && sh_en_sync) w_state_nxt = SHIFT;
      SHIFT: begin
        if (!active_i)                         w_state_nxt = IDLE;
        else if (!sh_en_sync && r_sh_en_prev)  w_state_nxt = CLOSE;
      end
      CLOSE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift register, saturating bit counter and sh_en edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg      <= '0;
      r_cnt        <= '0;
      r_sh_en_prev <= 1'b0;
    end else begin
      r_sh_en_prev <= sh_en_sync;
      if (r_state == IDLE && active_i && sh_en_sync) begin
        r_shreg <= {r_shreg[FRAME_LEN-2:0], sdi};
        r_cnt   <= CNT_W'(1);
      end else if (r_state == SHIFT && active_i && sh_en_sync) begin
        r_shreg <= {r_shreg[FRAME_LEN-2:0], sdi};
        if (r_cnt < SAT_C) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

`ifdef SH_PARITY_EN
  assign w_par_bad = ^r_shreg;
`else
  assign w_par_bad = 1'b0;
`endif

  // Output decode: frame verdict during CLOSE, driven from registered state.
  always_comb begin
    w_close   = (r_state == CLOSE);
    w_len_bad = w_close && (r_cnt != LEN_C);
    w_good    = w_close && (r_cnt == LEN_C) && !w_par_bad;
    w_load    = w_good && (!w_full || bus.ready_i);
    w_ovf     = w_good && w_full && !bus.ready_i;
  end

  assign bus.len_err_o = w_len_bad;
  assign bus.par_err_o = w_close && (r_cnt == LEN_C) && w_par_bad;
  assign bus.ovf_o     = w_ovf;

  sh_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .din   (r_shreg[FRAME_LEN-1 -: WIDTH]),
    .ready (bus.ready_i),
    .valid (bus.valid_o),
    .dout  (bus.word_o),
    .full  (w_full)
  );

endmodule
